// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets the instruction-fetch and load/store requesters
// share one single-port memory, one req/ready transaction at a time.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned     CNT_W    = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              err_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;

  logic              busy, grant_i, grant_d, timed_out, done;
  logic [DATA_W-1:0] rsp_rdata;

  assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    state_d   = state_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    // A ready in the limit cycle wins over the timeout.
    timed_out = busy && !mem_ready && (cnt_q == CNT_LAST);
    done      = busy && (mem_ready || timed_out);
    rsp_rdata = (mem_ready && !we_q) ? mem_rdata : '0;
    case (state_q)
      IDLE: begin
        grant_i = i_req && (!d_req || last_grant_q == GRANT_D);
        grant_d = d_req && !grant_i;
        if (grant_i)      state_d = BUSY_I;
        else if (grant_d) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: if (done) state_d = RESP;
      RESP:           state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      size_q       <= 2'b00;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (grant_i) begin
            addr_q       <= i_addr;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            size_q       <= 2'b10;
            last_grant_q <= GRANT_I;
          end else if (grant_d) begin
            addr_q       <= d_addr;
            we_q         <= d_we;
            wdata_q      <= d_wdata;
            size_q       <= d_size;
            last_grant_q <= GRANT_D;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            err_q <= timed_out;
            if (state_q == BUSY_I) i_rdata_q <= rsp_rdata;
            else                   d_rdata_q <= rsp_rdata;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_size  = size_q;

  // The ack goes to whichever side was granted last, which is the one just served.
  assign i_ack   = (state_q == RESP) && (last_grant_q == GRANT_I);
  assign d_ack   = (state_q == RESP) && (last_grant_q == GRANT_D);
  assign i_err   = i_ack && err_q;
  assign d_err   = d_ack && err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, multi-cycle
// corner sequences, then randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int TO     = 4;
  localparam bit SIDE_I = 1'b0;
  localparam bit SIDE_D = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_size;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    bit          ir;
    logic [31:0] ia;
    bit          dr;
    bit          dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [1:0]  dsz;
    int          wt;         // wait cycles before mem_ready; >= TO means never
    logic [31:0] rd;         // word the memory presents
    bit          exp_side;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                           input logic [31:0] da, input logic [31:0] dwd, input logic [1:0] dsz);
    i_req = ir;  i_addr = ia;
    d_req = dr;  d_we = dwe;  d_addr = da;  d_wdata = dwd;  d_size = dsz;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ctl"}, 96'({i_ack, i_err, d_ack, d_err, mem_req, mem_we, mem_size, mem_addr, mem_wdata}),
          96'(0));
    check({tag, " rdata"}, 96'({i_rdata, d_rdata}), 96'(0));
  endtask

  // One cycle with the arbiter expected idle; a stray mem_ready must be ignored.
  task automatic idle_step(input string tag);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    check(tag, 96'({mem_req, i_ack, i_err, d_ack, d_err}), 96'(0));
  endtask

  // Called at the falling edge of a cycle where the arbiter is idle and the requests are set.
  task automatic run_txn(input bit side, input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input logic [1:0] size, input int wt,
                         input logic [31:0] rd, input logic [31:0] exp_rdata,
                         input bit exp_err, input string tag);
    int hi;
    hi = (wt < TO) ? wt + 1 : TO;
    for (int k = 0; k < hi; k++) begin
      step();
      check({tag, " mem"}, 96'({mem_req, mem_we, mem_size, i_ack, d_ack, mem_addr}),
            96'({1'b1, we, size, 1'b0, 1'b0, addr}));
      if (we) check({tag, " wdata"}, 96'(mem_wdata), 96'(wdata));
      mem_ready = (k == wt);
      mem_rdata = rd;
    end
    step();
    mem_ready = 1'b0;
    if (side == SIDE_I) begin
      check({tag, " i_ack"}, 96'({mem_req, i_ack, d_ack, i_err}), 96'({1'b0, 1'b1, 1'b0, exp_err}));
      check({tag, " i_rdata"}, 96'(i_rdata), 96'(exp_rdata));
    end else begin
      check({tag, " d_ack"}, 96'({mem_req, d_ack, i_ack, d_err}), 96'({1'b0, 1'b1, 1'b0, exp_err}));
      check({tag, " d_rdata"}, 96'(d_rdata), 96'(exp_rdata));
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.exp_side == SIDE_I)
      run_txn(SIDE_I, v.ia, 1'b0, 32'h0, 2'b10, v.wt, v.rd, v.exp_rdata, v.exp_err, tag);
    else
      run_txn(SIDE_D, v.da, v.dwe, v.dwd, v.dsz, v.wt, v.rd, v.exp_rdata, v.exp_err, tag);
  endtask

  // Randomized traffic state
  bit          i_pend, d_pend, at_ack, m_last, winner;
  logic [31:0] r_ia, r_da, r_dwd, rd, exp_rd;
  logic        r_dwe;
  logic [1:0]  r_dsz;
  int          wt;
  bit          exp_err;

  initial begin
    reset = 1'b1;
    drive_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    //              ir    ia          dr    dwe   da          dwd           dsz    wt  rd            side    exp_rdata     err
    vecs[0]  = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0,        2'b10, 0,  32'h00500093, SIDE_I, 32'h00500093, 1'b0};
    vecs[1]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h200, 32'h0,        2'b10, 1,  32'h11112222, SIDE_D, 32'h11112222, 1'b0};
    vecs[2]  = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h204, 32'h0,        2'b10, 0,  32'h33334444, SIDE_I, 32'h33334444, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h204, 32'h0,        2'b10, 2,  32'h55556666, SIDE_D, 32'h55556666, 1'b0};
    vecs[4]  = '{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 2,  32'h0BADF00D, SIDE_I, 32'h0BADF00D, 1'b0};
    vecs[5]  = '{1'b1, 32'h304, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 0,  32'h12345678, SIDE_I, 32'h12345678, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h40,  32'hDEADBEEF, 2'b00, 3,  32'hCAFEF00D, SIDE_D, 32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h80,  32'h0,        2'b01, 99, 32'hA5A5A5A5, SIDE_D, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h84,  32'h0,        2'b00, 0,  32'h000000AB, SIDE_D, 32'h000000AB, 1'b0};
    vecs[9]  = '{1'b1, 32'h500, 1'b0, 1'b0, 32'h0,   32'h0,        2'b00, 99, 32'h77777777, SIDE_I, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h88,  32'h01020304, 2'b01, 1,  32'hFFFFFFFF, SIDE_D, 32'h0,        1'b0};

    @(negedge clk);
    step();
    check_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive_req(vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd, vecs[i].dsz);
      if (i > 0) idle_step($sformatf("vec%0d idle", i));
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // d_req held one cycle past d_ack: an identical store is issued again.
    idle_step("hold idle");
    run_txn(SIDE_D, 32'h88, 1'b1, 32'h01020304, 2'b01, 0, 32'h13579BDF, 32'h0, 1'b0, "hold");

    // Reset in the third busy cycle of a load, with a fetch arriving meanwhile.
    drive_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h3C0, 32'h0, 2'b10);
    idle_step("abort idle");
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      mem_ready = 1'b0;
      check($sformatf("abort busy%0d", k), 96'({mem_req, mem_addr}), 96'({1'b1, 32'h3C0}));
    end
    reset = 1'b1;
    i_req = 1'b1;
    i_addr = 32'h700;
    step();
    check_all_zero("abort reset");
    reset = 1'b0;
    run_txn(SIDE_I, 32'h700, 1'b0, 32'h0, 2'b10, 1, 32'h2468ACE0, 32'h2468ACE0, 1'b0, "post reset I");
    i_req = 1'b0;
    idle_step("post reset idle");
    run_txn(SIDE_D, 32'h3C0, 1'b0, 32'h0, 2'b10, 0, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0, "post reset D");

    // Randomized traffic: each side either holds its pending request or may raise a new one.
    drive_req(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    reset = 1'b1;
    step();
    step();
    reset  = 1'b0;
    m_last = SIDE_D;
    i_pend = 1'b0;
    d_pend = 1'b0;
    at_ack = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        r_ia   = $urandom;
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1;
        r_dwe  = 1'($urandom_range(0, 1));
        r_da   = $urandom;
        r_dwd  = $urandom;
        r_dsz  = 2'($urandom_range(0, 2));
      end
      drive_req(i_pend, i_pend ? r_ia : $urandom, d_pend, r_dwe, d_pend ? r_da : $urandom, r_dwd, r_dsz);
      if (at_ack || (!i_pend && !d_pend)) idle_step("rand idle");
      at_ack = 1'b0;
      if (!i_pend && !d_pend) continue;

      winner  = (i_pend && d_pend) ? !m_last : d_pend;
      m_last  = winner;
      wt      = $urandom_range(0, TO + 1);
      rd      = $urandom;
      exp_err = (wt >= TO);
      exp_rd  = (exp_err || (winner == SIDE_D && r_dwe)) ? 32'h0 : rd;
      if (winner == SIDE_I) begin
        run_txn(SIDE_I, r_ia, 1'b0, 32'h0, 2'b10, wt, rd, exp_rd, exp_err, $sformatf("rand%0d I", t));
        i_pend = 1'b0;
      end else begin
        run_txn(SIDE_D, r_da, r_dwe, r_dwd, r_dsz, wt, rd, exp_rd, exp_err, $sformatf("rand%0d D", t));
        d_pend = 1'b0;
      end
      at_ack = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
